// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared state encoding, config word layout and word builder for the I2C config sequencer
package i2c_cfg_pkg;
  typedef enum logic [2:0] {PWRUP, LOAD, REQ, WAIT_END, CHECK, GAP, DONE, FAIL} state_t;
  typedef logic [23:0] cfg_word_t;
  localparam int FIELD_W = 8;
  localparam int SLV_LSB = 16;
  localparam int REG_LSB = 8;
  localparam int DAT_LSB = 0;
  function automatic cfg_word_t mk_word(input logic [7:0] s, input logic [7:0] r, input logic [7:0] d);
    cfg_word_t w;
    w = '0;
    w[SLV_LSB +: FIELD_W] = s;
    w[REG_LSB +: FIELD_W] = r;
    w[DAT_LSB +: FIELD_W] = d;
    return w;
  endfunction
endpackage

// File: rtl/i2c_config_rom.sv
// i2c_config_rom: power-up register table for the board codec (0x34) and sensor (0x42);
// entries at or beyond TABLE_LEN read as zero.
module i2c_config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int TABLE_LEN = 16,
  parameter int IW = 4
) (
  input  logic [IW-1:0] idx,
  output cfg_word_t     word
);
  cfg_word_t entry;
  always_comb begin
    case (32'(idx))
      0:       entry = mk_word(8'h34, 8'h1E, 8'h00);
      1:       entry = mk_word(8'h34, 8'h0C, 8'h00);
      2:       entry = mk_word(8'h34, 8'h0E, 8'h42);
      3:       entry = mk_word(8'h34, 8'h10, 8'h00);
      4:       entry = mk_word(8'h34, 8'h00, 8'h17);
      5:       entry = mk_word(8'h34, 8'h02, 8'h17);
      6:       entry = mk_word(8'h34, 8'h04, 8'h79);
      7:       entry = mk_word(8'h34, 8'h06, 8'h79);
      8:       entry = mk_word(8'h34, 8'h08, 8'h12);
      9:       entry = mk_word(8'h34, 8'h0A, 8'h06);
      10:      entry = mk_word(8'h34, 8'h12, 8'h01);
      11:      entry = mk_word(8'h42, 8'h12, 8'h80);
      12:      entry = mk_word(8'h42, 8'h11, 8'h01);
      13:      entry = mk_word(8'h42, 8'h0C, 8'h04);
      14:      entry = mk_word(8'h42, 8'h3E, 8'h00);
      15:      entry = mk_word(8'h42, 8'h40, 8'hD0);
      default: entry = '0;
    endcase
  end
  assign word = 32'(idx) < TABLE_LEN ? entry : '0;
endmodule

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks the config ROM after reset and hands each word to the I2C write controller.
// Define I2C_CFG_STATUS_EN to add the cfg_idx / nack_cnt status outputs.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int TABLE_LEN = 16,
  parameter int PWRUP_CYC = 50000,
  parameter int GAP_CYC   = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  output cfg_word_t i2c_data,
  output logic      go,
  input  logic      i2c_end,
  input  logic      ack,
  output logic      cfg_done,
  output logic      cfg_fail,
  output logic      cfg_busy
`ifdef I2C_CFG_STATUS_EN
  ,
  output logic [7:0] cfg_idx,
  output logic [7:0] nack_cnt
`endif
);
  localparam int IW = TABLE_LEN > 1 ? $clog2(TABLE_LEN) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CMAX = PWRUP_CYC > GAP_CYC ? PWRUP_CYC : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST = IW'(TABLE_LEN - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [CW-1:0] PW_END = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);

  state_t          state, nxt;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   retry;
  logic [CW-1:0]   cnt;
  logic            start_q, end_low, ack_q;
  cfg_word_t       rom_word;

  i2c_config_rom #(.TABLE_LEN(TABLE_LEN), .IW(IW)) u_rom (.idx(idx), .word(rom_word));

  // end_low records an END=0 sample since entering REQ/GAP, so a stale END level is never taken as fresh
  logic start_rise, pw_done, gap_hit, armed, xfer_done, last, can_retry, restart, cnt_en;
  assign start_rise = start & ~start_q;
  assign pw_done    = cnt == PW_END;
  assign gap_hit    = cnt == GAP_END;
  assign armed      = end_low | ~i2c_end;
  assign xfer_done  = end_low & i2c_end;
  assign last       = idx == LAST;
  assign can_retry  = retry < RMAX;
  assign restart    = (state == DONE || state == FAIL) && start_rise;
  assign cnt_en     = (state == PWRUP && !pw_done) || (state == GAP && armed && !gap_hit);

  always_comb begin
    nxt = state;
    case (state)
      PWRUP:     nxt = pw_done ? LOAD : PWRUP;
      LOAD:      nxt = REQ;
      REQ:       nxt = WAIT_END;
      WAIT_END:  nxt = xfer_done ? CHECK : WAIT_END;
      CHECK:     nxt = ack_q ? (last ? DONE : GAP) : (can_retry ? GAP : FAIL);
      GAP:       nxt = armed && gap_hit ? LOAD : GAP;
      DONE, FAIL: nxt = start_rise ? LOAD : state;
      default:   nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= PWRUP;
    else state <= nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      retry    <= '0;
      cnt      <= '0;
      i2c_data <= '0;
      start_q  <= 1'b0;
      end_low  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      start_q <= start;
      end_low <= (state == REQ || state == WAIT_END || state == GAP) && armed;
      if (state == LOAD) i2c_data <= rom_word;
      if (state == WAIT_END && xfer_done) ack_q <= ack;
      if (state == CHECK) cnt <= '0;
      else if (cnt_en) cnt <= cnt + 1'b1;
      if (state == CHECK && ack_q) begin
        retry <= '0;
        if (!last) idx <= idx + 1'b1;
      end else if (state == CHECK && can_retry) retry <= retry + 1'b1;
      if (restart) begin
        idx   <= '0;
        retry <= '0;
      end
    end
  end

  // state-decoded so reset drops go immediately
  assign go       = state == REQ || state == WAIT_END;
  assign cfg_done = state == DONE;
  assign cfg_fail = state == FAIL;
  assign cfg_busy = !(cfg_done || cfg_fail);

`ifdef I2C_CFG_STATUS_EN
  assign cfg_idx = 8'(idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nack_cnt <= '0;
    else if (restart) nack_cnt <= '0;
    else if (state == CHECK && !ack_q && nack_cnt != 8'hFF) nack_cnt <= nack_cnt + 1'b1;
`endif
endmodule
